yuv422_to_444: RTL and testbench

YUV422_TO_444 -- requirements
Module: yuv422_to_444

---
 rtl/yuv_pkg.sv | 18 +
 rtl/yuv422_to_444.sv | 110 +++++++++++
 tb/tb_yuv422_to_444.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/yuv_pkg.sv
// Shared definitions for the YUV pixel pipeline (4:2:2 upsampler, yuv2rgb).
package yuv_pkg;

   // Default bits per colour component.
   localparam int unsigned DsizeDefault = 8;

   // Field offsets within a packed {Y, Cb, Cr} word, in units of one component.
   localparam int unsigned YOffset  = 2;
   localparam int unsigned CbOffset = 1;
   localparam int unsigned CrOffset = 0;

   // Pair phase: StEven expects pixel 0 of a pair, StOdd holds pixel 0.
   typedef enum logic {
      StEven,
      StOdd
   } phase_e;

endpackage

// File: rtl/yuv422_to_444.sv
// 4:2:2 to 4:4:4 chroma upsampler by replication. Each input pair
// (Y0,C0),(Y1,C1) yields (Y0,Cb,Cr) then (Y1,Cb,Cr); outputs come straight from flops.
module yuv422_to_444
   import yuv_pkg::*;
#(
   parameter int unsigned DSIZE    = DsizeDefault,
   parameter bit          CB_FIRST = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_vld,
   input  logic               in_sol,
   input  logic [2*DSIZE-1:0] in_data,
   output logic               y_cb_cr_vld,
   output logic [3*DSIZE-1:0] y_cb_cr,
   output logic               err_odd
);

   phase_e             state_q, state_d;
   logic [DSIZE-1:0]   hold_y_q, hold_y_d;
   logic [DSIZE-1:0]   hold_c_q, hold_c_d;
   logic [DSIZE-1:0]   pend_y_q, pend_y_d;
   logic               pend_vld_q, pend_vld_d;
   logic [DSIZE-1:0]   cb_q, cb_d;
   logic [DSIZE-1:0]   cr_q, cr_d;
   logic [3*DSIZE-1:0] out_q, out_d;
   logic               out_vld_q, out_vld_d;
   logic               err_q, err_d;

   logic [DSIZE-1:0]   in_y;
   logic [DSIZE-1:0]   in_c;

   assign in_y = in_data[2*DSIZE-1:DSIZE];
   assign in_c = in_data[DSIZE-1:0];

   // Phase FSM next state, hold/pending capture and registered output selection.
   always_comb begin
      state_d    = state_q;
      hold_y_d   = hold_y_q;
      hold_c_d   = hold_c_q;
      pend_y_d   = pend_y_q;
      pend_vld_d = 1'b0;
      cb_d       = cb_q;
      cr_d       = cr_q;
      out_d      = out_q;
      out_vld_d  = 1'b0;
      err_d      = 1'b0;

      // Pending Y1 always goes out; an odd-pixel accept cannot coincide since
      // the cycle after one leaves the FSM in StEven.
      if (pend_vld_q) begin
         out_vld_d                            = 1'b1;
         out_d[YOffset*DSIZE +: DSIZE]  = pend_y_q;
         out_d[CbOffset*DSIZE +: DSIZE] = cb_q;
         out_d[CrOffset*DSIZE +: DSIZE] = cr_q;
      end

      if (in_vld) begin
         if (in_sol || (state_q == StEven)) begin
            // Start of a pair; a line restart while holding drops the held pixel.
            hold_y_d = in_y;
            hold_c_d = in_c;
            state_d  = StOdd;
            err_d    = in_sol && (state_q == StOdd);
         end else begin
            cb_d                                 = CB_FIRST ? hold_c_q : in_c;
            cr_d                                 = CB_FIRST ? in_c : hold_c_q;
            out_vld_d                            = 1'b1;
            out_d[YOffset*DSIZE +: DSIZE]  = hold_y_q;
            out_d[CbOffset*DSIZE +: DSIZE] = cb_d;
            out_d[CrOffset*DSIZE +: DSIZE] = cr_d;
            pend_y_d                             = in_y;
            pend_vld_d                           = 1'b1;
            state_d                              = StEven;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StEven;
         hold_y_q   <= '0;
         hold_c_q   <= '0;
         pend_y_q   <= '0;
         pend_vld_q <= 1'b0;
         cb_q       <= '0;
         cr_q       <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_y_q   <= hold_y_d;
         hold_c_q   <= hold_c_d;
         pend_y_q   <= pend_y_d;
         pend_vld_q <= pend_vld_d;
         cb_q       <= cb_d;
         cr_q       <= cr_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         err_q      <= err_d;
      end
   end

   assign y_cb_cr_vld = out_vld_q;
   assign y_cb_cr     = out_q;
   assign err_odd     = err_q;

endmodule

// File: tb/tb_yuv422_to_444.sv
// Directed bench for yuv422_to_444: one instance per chroma ordering, shared stimulus.
module tb_yuv422_to_444;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_vld;
   logic        in_sol;
   logic [15:0] in_data;
   logic        vld_a, vld_b;
   logic [23:0] out_a, out_b;
   logic        err_a, err_b;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   yuv422_to_444 #(.DSIZE(8), .CB_FIRST(1'b1)) dut (
      .clock       (clk),
      .reset       (rst),
      .in_vld      (in_vld),
      .in_sol      (in_sol),
      .in_data     (in_data),
      .y_cb_cr_vld (vld_a),
      .y_cb_cr     (out_a),
      .err_odd     (err_a)
   );

   yuv422_to_444 #(.DSIZE(8), .CB_FIRST(1'b0)) dut_cr (
      .clock       (clk),
      .reset       (rst),
      .in_vld      (in_vld),
      .in_sol      (in_sol),
      .in_data     (in_data),
      .y_cb_cr_vld (vld_b),
      .y_cb_cr     (out_b),
      .err_odd     (err_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Apply one cycle of input, then sample just after the edge.
   task automatic step(input logic vld, input logic sol, input logic [7:0] y,
                       input logic [7:0] c);
      in_vld  = vld;
      in_sol  = sol;
      in_data = {y, c};
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   logic [7:0]  ly [8];
   logic [7:0]  lc [8];
   logic [23:0] exp_px;

   initial begin
      rst = 1'b1;
      in_vld = 1'b0; in_sol = 1'b0; in_data = '0;
      idle();
      idle();
      check("rst_vld", {31'd0, vld_a}, 32'd0);
      check("rst_data", {8'd0, out_a}, 32'd0);
      check("rst_err", {31'd0, err_a}, 32'd0);
      rst = 1'b0;

      // Basic pair, back-to-back.
      step(1'b1, 1'b1, 8'h10, 8'h80);
      check("pair_p0_vld", {31'd0, vld_a}, 32'd0);
      step(1'b1, 1'b0, 8'h20, 8'h90);
      check("pair_o0_vld", {31'd0, vld_a}, 32'd1);
      check("pair_o0", {8'd0, out_a}, 32'h108090);
      idle();
      check("pair_o1_vld", {31'd0, vld_a}, 32'd1);
      check("pair_o1", {8'd0, out_a}, 32'h208090);
      idle();
      check("pair_idle_vld", {31'd0, vld_a}, 32'd0);
      check("pair_hold", {8'd0, out_a}, 32'h208090);

      // Chroma ordering swapped on the second instance.
      step(1'b1, 1'b1, 8'h10, 8'hAA);
      step(1'b1, 1'b0, 8'h20, 8'hBB);
      check("cr_o0", {8'd0, out_b}, 32'h10BBAA);
      check("cb_o0", {8'd0, out_a}, 32'h10AABB);
      idle();
      check("cr_o1_vld", {31'd0, vld_b}, 32'd1);
      check("cr_o1", {8'd0, out_b}, 32'h20BBAA);
      idle();

      // Continuous 8-pixel line.
      for (int i = 0; i < 8; i++) begin
         ly[i] = 8'h30 + 8'(i);
         lc[i] = 8'h50 + 8'(i);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, (i == 0), ly[i], lc[i]);
         if (i == 0) begin
            check("line_p0_vld", {31'd0, vld_a}, 32'd0);
         end else begin
            if (i % 2 == 1) exp_px = {ly[i-1], lc[i-1], lc[i]};
            else            exp_px = {ly[i-1], lc[i-2], lc[i-1]};
            check("line_vld", {31'd0, vld_a}, 32'd1);
            check("line_px", {8'd0, out_a}, {8'd0, exp_px});
         end
      end
      idle();
      check("line_last_vld", {31'd0, vld_a}, 32'd1);
      check("line_last", {8'd0, out_a}, {8'd0, ly[7], lc[6], lc[7]});
      idle();
      check("line_end_vld", {31'd0, vld_a}, 32'd0);

      // Gap between pixel 0 and pixel 1.
      step(1'b1, 1'b1, 8'h61, 8'h71);
      for (int i = 0; i < 3; i++) begin
         idle();
         check("gap_vld", {31'd0, vld_a}, 32'd0);
      end
      step(1'b1, 1'b0, 8'h62, 8'h72);
      check("gap_o0", {8'd0, out_a}, 32'h617172);
      idle();
      check("gap_o1", {8'd0, out_a}, 32'h627172);
      check("gap_o1_vld", {31'd0, vld_a}, 32'd1);
      idle();

      // Line restart while holding pixel 0.
      step(1'b1, 1'b1, 8'h55, 8'h66);
      step(1'b1, 1'b1, 8'h40, 8'h11);
      check("sol_err", {31'd0, err_a}, 32'd1);
      check("sol_drop_vld", {31'd0, vld_a}, 32'd0);
      step(1'b1, 1'b0, 8'h41, 8'h22);
      check("sol_err_clr", {31'd0, err_a}, 32'd0);
      check("sol_o0", {8'd0, out_a}, 32'h401122);
      idle();
      check("sol_o1", {8'd0, out_a}, 32'h411122);
      idle();

      // in_sol on the cycle the pending Y1 is due: Y1 still emitted, no error.
      step(1'b1, 1'b1, 8'h01, 8'hA1);
      step(1'b1, 1'b0, 8'h02, 8'hA2);
      step(1'b1, 1'b1, 8'h03, 8'hA3);
      check("due_vld", {31'd0, vld_a}, 32'd1);
      check("due_y1", {8'd0, out_a}, 32'h02A1A2);
      check("due_err", {31'd0, err_a}, 32'd0);
      step(1'b1, 1'b0, 8'h04, 8'hA4);
      check("due_next", {8'd0, out_a}, 32'h03A3A4);
      idle();
      idle();

      // in_sol without in_vld is ignored.
      step(1'b1, 1'b1, 8'h05, 8'hB5);
      step(1'b0, 1'b1, 8'h99, 8'h99);
      check("solnv_vld", {31'd0, vld_a}, 32'd0);
      check("solnv_err", {31'd0, err_a}, 32'd0);
      step(1'b1, 1'b0, 8'h06, 8'hB6);
      check("solnv_o0", {8'd0, out_a}, 32'h05B5B6);
      idle();
      idle();

      // Reset mid-pair: held pixel discarded, next pixel is pixel 0.
      step(1'b1, 1'b1, 8'h77, 8'h88);
      rst = 1'b1;
      idle();
      check("rstodd_vld", {31'd0, vld_a}, 32'd0);
      check("rstodd_err", {31'd0, err_a}, 32'd0);
      check("rstodd_data", {8'd0, out_a}, 32'd0);
      rst = 1'b0;
      step(1'b1, 1'b0, 8'h01, 8'h02);
      check("rstodd_p0_vld", {31'd0, vld_a}, 32'd0);
      check("rstodd_p0_err", {31'd0, err_a}, 32'd0);
      step(1'b1, 1'b0, 8'h03, 8'h04);
      check("rstodd_o0", {8'd0, out_a}, 32'h010204);
      idle();
      check("rstodd_o1", {8'd0, out_a}, 32'h030204);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
